// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter slice: default widths,
// execution-unit source indices and the broadcast bus record.
package cdb_pkg;

    localparam int CDB_N_SRC  = 3;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    localparam int SRC_ADD = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

    // Width of a pointer that can index n sources (at least one bit).
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_arb.sv
// Combinational arbiter: scans the request vector starting at ptr_i and
// wrapping around, granting the first requester found (one-hot grant).
// Tying ptr_i to zero turns it into a fixed lowest-index-first arbiter.
module cdb_rr_arb
    import cdb_pkg::*;
#(
    parameter  int N  = CDB_N_SRC,
    localparam int PW = ptrWidth(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    int   idx;
    logic found;

    // Walk the sources in rotated order and grant the first pending one.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: each execution unit parks one result in a holding
// slot; one slot per cycle is chosen and broadcast on the registered CDB.
// Define CDB_RR_ARB_EN for round-robin arbitration; otherwise fixed priority
// with source 0 highest and no pointer register.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC  = CDB_N_SRC,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data
);

    localparam int PW = ptrWidth(N_SRC);

    logic [N_SRC-1:0]  holdValid_q, holdValid_d;
    logic [TAG_W-1:0]  holdTag_q  [N_SRC];
    logic [TAG_W-1:0]  holdTag_d  [N_SRC];
    logic [DATA_W-1:0] holdData_q [N_SRC];
    logic [DATA_W-1:0] holdData_d [N_SRC];

    logic              cdbValid_q, cdbValid_d;
    logic [TAG_W-1:0]  cdbTag_q,   cdbTag_d;
    logic [DATA_W-1:0] cdbData_q,  cdbData_d;

    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  xfer;
    logic [PW-1:0]     arbPtr;

`ifdef CDB_RR_ARB_EN
    logic [PW-1:0]     rrPtr_q, rrPtr_d;
    assign arbPtr = rrPtr_q;
`else
    assign arbPtr = '0;
`endif

    cdb_rr_arb #(
        .N (N_SRC)
    ) u_arb (
        .req_i   (holdValid_q),
        .ptr_i   (arbPtr),
        .grant_o (grant)
    );

    // A slot can accept when empty or when it is draining this cycle.
    assign src_ready = (rst || flush) ? '0 : (~holdValid_q | grant);
    assign xfer      = src_valid & src_ready;

    // Next state: slots drain on grant and load on transfer; the granted slot
    // is copied onto the bus; flush squashes both slots and broadcast.
    always_comb begin
        holdValid_d = (holdValid_q & ~grant) | xfer;
        if (flush) begin
            holdValid_d = '0;
        end
        for (int i = 0; i < N_SRC; i++) begin
            holdTag_d[i]  = xfer[i] ? src_tag[i*TAG_W +: TAG_W]    : holdTag_q[i];
            holdData_d[i] = xfer[i] ? src_data[i*DATA_W +: DATA_W] : holdData_q[i];
        end
        cdbValid_d = 1'b0;
        cdbTag_d   = cdbTag_q;
        cdbData_d  = cdbData_q;
`ifdef CDB_RR_ARB_EN
        rrPtr_d    = rrPtr_q;
`endif
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i] && !flush) begin
                cdbValid_d = 1'b1;
                cdbTag_d   = holdTag_q[i];
                cdbData_d  = holdData_q[i];
`ifdef CDB_RR_ARB_EN
                rrPtr_d    = PW'((i + 1) % N_SRC);
`endif
            end
        end
    end

    // State registers with asynchronous reset clearing everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdValid_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                holdTag_q[i]  <= '0;
                holdData_q[i] <= '0;
            end
            cdbValid_q <= 1'b0;
            cdbTag_q   <= '0;
            cdbData_q  <= '0;
`ifdef CDB_RR_ARB_EN
            rrPtr_q    <= '0;
`endif
        end else begin
            holdValid_q <= holdValid_d;
            for (int i = 0; i < N_SRC; i++) begin
                holdTag_q[i]  <= holdTag_d[i];
                holdData_q[i] <= holdData_d[i];
            end
            cdbValid_q <= cdbValid_d;
            cdbTag_q   <= cdbTag_d;
            cdbData_q  <= cdbData_d;
`ifdef CDB_RR_ARB_EN
            rrPtr_q    <= rrPtr_d;
`endif
        end
    end

    assign cdb_valid = cdbValid_q;
    assign cdb_tag   = cdbTag_q;
    assign cdb_data  = cdbData_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: expected broadcasts go into a queue as
// stimulus is issued, and a monitor pops and compares every CDB broadcast.
// Expectations that depend on CDB_RR_ARB_EN follow the same macro.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [11:0] src_tag;
    logic [95:0] src_data;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;

    cdb_bus_t expQ [$];
    cdb_bus_t monEntry;
    int       checks = 0;
    int       errors = 0;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                                 input logic [3:0] t2, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic f);
        src_valid = v;
        src_tag   = {t2, t1, t0};
        src_data  = {d2, d1, d0};
        flush     = f;
    endtask

    task automatic idle();
        applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic pushExp(input logic [3:0] t, input logic [31:0] d);
        cdb_bus_t e;
        e.valid = 1'b1;
        e.tag   = t;
        e.data  = d;
        expQ.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && expQ.size() != 0; i++) nextCycle();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d broadcasts outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (3) nextCycle();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        idle();
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    // Monitor: every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && cdb_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_bcast: got tag 0x%0h data 0x%0h, expected no broadcast",
                         cdb_tag, cdb_data);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("bcast_tag", {28'h0, cdb_tag}, {28'h0, monEntry.tag});
                checkOutput("bcast_data", cdb_data, monEntry.data);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();

        // Reset state
        nextCycle();
        #2;
        checkOutput("rst_cdb_valid", {31'h0, cdb_valid}, 32'h0);
        checkOutput("rst_cdb_tag", {28'h0, cdb_tag}, 32'h0);
        checkOutput("rst_cdb_data", cdb_data, 32'h0);
        checkOutput("rst_ready", {29'h0, src_ready}, 32'h0);
        nextCycle();
        rst = 1'b0;

        // Single add result, two-edge latency
        $display("[TB] single add result");
        applyStimulus(3'b001, 4'd3, 4'd0, 4'd0, 32'hAA, 32'h0, 32'h0, 1'b0);
        pushExp(4'd3, 32'hAA);
        #2 checkOutput("single_ready0_c0", {31'h0, src_ready[0]}, 32'h1);
        nextCycle();
        idle();
        #2 checkOutput("single_ready0_c1", {31'h0, src_ready[0]}, 32'h1);
        checkOutput("single_valid_c1", {31'h0, cdb_valid}, 32'h0);
        nextCycle();
        #2 checkOutput("single_valid_c2", {31'h0, cdb_valid}, 32'h1);
        checkOutput("single_tag_c2", {28'h0, cdb_tag}, 32'd3);
        checkOutput("single_ready0_c2", {31'h0, src_ready[0]}, 32'h1);
        nextCycle();
        #2 checkOutput("single_valid_c3", {31'h0, cdb_valid}, 32'h0);
        checkOutput("single_tag_hold", {28'h0, cdb_tag}, 32'd3);
        drain();

        // Three simultaneous results, broadcast on consecutive cycles
        $display("[TB] simultaneous burst");
        applyReset();
        applyStimulus(3'b111, 4'd1, 4'd2, 4'd3, 32'h11, 32'h22, 32'h33, 1'b0);
        pushExp(4'd1, 32'h11);
        pushExp(4'd2, 32'h22);
        pushExp(4'd3, 32'h33);
        #2 checkOutput("burst_ready_c0", {29'h0, src_ready}, 32'h7);
        nextCycle();
        idle();
        #2 checkOutput("burst_ready_c1", {29'h0, src_ready}, 32'h1);
        nextCycle();
        #2 checkOutput("burst_valid_c2", {31'h0, cdb_valid}, 32'h1);
        checkOutput("burst_tag_c2", {28'h0, cdb_tag}, 32'd1);
        checkOutput("burst_ready_c2", {29'h0, src_ready}, 32'h3);
        nextCycle();
        #2 checkOutput("burst_valid_c3", {31'h0, cdb_valid}, 32'h1);
        checkOutput("burst_tag_c3", {28'h0, cdb_tag}, 32'd2);
        checkOutput("burst_ready_c3", {29'h0, src_ready}, 32'h7);
        nextCycle();
        #2 checkOutput("burst_valid_c4", {31'h0, cdb_valid}, 32'h1);
        checkOutput("burst_tag_c4", {28'h0, cdb_tag}, 32'd3);
        nextCycle();
        #2 checkOutput("burst_valid_c5", {31'h0, cdb_valid}, 32'h0);
        applyStimulus(3'b111, 4'd4, 4'd5, 4'd6, 32'h44, 32'h55, 32'h66, 1'b0);
        pushExp(4'd4, 32'h44);
        pushExp(4'd5, 32'h55);
        pushExp(4'd6, 32'h66);
        nextCycle();
        idle();
        nextCycle();
        #2 checkOutput("burst2_first_tag", {28'h0, cdb_tag}, 32'd4);
        drain();

        // Back-to-back stream from source 0
        $display("[TB] source 0 stream");
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                applyStimulus(3'b001, 4'(8 + i), 4'd0, 4'd0, 32'h100 + i, 32'h0, 32'h0, 1'b0);
                pushExp(4'(8 + i), 32'h100 + i);
            end else begin
                idle();
            end
            #2 checkOutput("stream_ready0", {31'h0, src_ready[0]}, 32'h1);
            if (i >= 2) begin
                checkOutput("stream_valid", {31'h0, cdb_valid}, 32'h1);
                checkOutput("stream_tag", {28'h0, cdb_tag}, 32'(8 + i - 2));
            end
            nextCycle();
        end
        drain();

        // Two contenders: order shows whether the pointer moved past source 0
        $display("[TB] pointer ordering");
        applyStimulus(3'b011, 4'd7, 4'd8, 4'd0, 32'h70, 32'h80, 32'h0, 1'b0);
`ifdef CDB_RR_ARB_EN
        pushExp(4'd8, 32'h80);
        pushExp(4'd7, 32'h70);
`else
        pushExp(4'd7, 32'h70);
        pushExp(4'd8, 32'h80);
`endif
        nextCycle();
        idle();
        nextCycle();
`ifdef CDB_RR_ARB_EN
        #2 checkOutput("order_first_tag", {28'h0, cdb_tag}, 32'd8);
`else
        #2 checkOutput("order_first_tag", {28'h0, cdb_tag}, 32'd7);
`endif
        drain();

`ifndef CDB_RR_ARB_EN
        // Fixed priority starves source 2 while source 0 streams
        $display("[TB] fixed priority starvation");
        applyStimulus(3'b101, 4'd9, 4'd0, 4'd2, 32'h90, 32'h0, 32'h22, 1'b0);
        pushExp(4'd9, 32'h90);
        #2 checkOutput("starve_ready_c0", {29'h0, src_ready}, 32'h7);
        for (int c = 1; c < 5; c++) begin
            nextCycle();
            applyStimulus(3'b001, 4'(9 + c), 4'd0, 4'd0, 32'h90 + c, 32'h0, 32'h0, 1'b0);
            pushExp(4'(9 + c), 32'h90 + c);
            #2 checkOutput("starve_ready2", {31'h0, src_ready[2]}, 32'h0);
            checkOutput("starve_ready0", {31'h0, src_ready[0]}, 32'h1);
        end
        nextCycle();
        idle();
        pushExp(4'd2, 32'h22);
        #2 checkOutput("starve_ready2_last", {31'h0, src_ready[2]}, 32'h0);
        nextCycle();
        #2 checkOutput("starve_ready2_free", {31'h0, src_ready[2]}, 32'h1);
        drain();
`endif

        // Flush with two full slots while a broadcast is on the bus
        $display("[TB] flush");
        applyStimulus(3'b111, 4'd4, 4'd5, 4'd6, 32'h40, 32'h50, 32'h60, 1'b0);
        nextCycle();
        idle();
`ifdef CDB_RR_ARB_EN
        pushExp(4'd5, 32'h50);
`else
        pushExp(4'd4, 32'h40);
`endif
        nextCycle();
        #2 checkOutput("flush_pre_valid", {31'h0, cdb_valid}, 32'h1);
        applyStimulus(3'b001, 4'd7, 4'd0, 4'd0, 32'h77, 32'h0, 32'h0, 1'b1);
        #1 checkOutput("flush_ready", {29'h0, src_ready}, 32'h0);
        nextCycle();
        idle();
        #2 checkOutput("flush_post_valid", {31'h0, cdb_valid}, 32'h0);
        checkOutput("flush_post_ready", {29'h0, src_ready}, 32'h7);
        drain();

        // Asynchronous reset between edges in the middle of a burst
        $display("[TB] async reset mid-burst");
        applyStimulus(3'b111, 4'd1, 4'd2, 4'd3, 32'hA1, 32'hA2, 32'hA3, 1'b0);
        nextCycle();
        idle();
        nextCycle();
        #2 rst = 1'b1;
        #1 checkOutput("arst_valid", {31'h0, cdb_valid}, 32'h0);
        checkOutput("arst_tag", {28'h0, cdb_tag}, 32'h0);
        checkOutput("arst_data", cdb_data, 32'h0);
        checkOutput("arst_ready", {29'h0, src_ready}, 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(3'b010, 4'd0, 4'd9, 4'd0, 32'h0, 32'h99, 32'h0, 1'b0);
        pushExp(4'd9, 32'h99);
        nextCycle();
        idle();
        nextCycle();
        #2 checkOutput("arst_new_valid", {31'h0, cdb_valid}, 32'h1);
        checkOutput("arst_new_tag", {28'h0, cdb_tag}, 32'd9);
        drain();

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_SRC, default 3; number of execution-unit result sources (0=add, 1=mul, 2=div).
REQ-002 Parameter TAG_W, default 4; reservation-station tag width.
REQ-003 Parameter DATA_W, default 32; result data width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous squash of all pending and outgoing results.
REQ-007 src_valid  input  N_SRC  per-source result-valid.
REQ-008 src_ready  output  N_SRC  per-source accept; a result transfers when valid and ready are both high at a clock edge.
REQ-009 src_tag  input  N_SRC*TAG_W  per-source producing-station tag; source i occupies bits [i*TAG_W +: TAG_W].
REQ-010 src_data  input  N_SRC*DATA_W  per-source result value; packed the same way as src_tag.
REQ-011 cdb_valid  output  1  broadcast-valid, registered.
REQ-012 cdb_tag  output  TAG_W  broadcast tag, registered.
REQ-013 cdb_data  output  DATA_W  broadcast value, registered.

Function
REQ-014 Each source has one holding slot (hold_valid, hold_tag, hold_data); a transfer loads its slot.
REQ-015 src_ready[i] = !flush && (!hold_valid[i] || grant[i]); it is combinational from the slot state and the current-cycle grant.
REQ-016 Arbitration is combinational over hold_valid and grants at most one slot per cycle.
REQ-017 Granted slot: at the next edge, its tag and data are driven on cdb_tag/cdb_data with cdb_valid=1, and its hold_valid is cleared, unless it is reloaded in the same cycle.
REQ-018 Latency: a result accepted at edge k, if granted in the cycle after edge k, appears on the CDB in the cycle after edge k+1.
REQ-019 No grant in a cycle: cdb_valid=0 after the next edge; cdb_tag and cdb_data hold their previous values.
REQ-020 The CDB has no backpressure; every granted result is broadcast for exactly one cycle.
REQ-021 A grant and a new transfer on the same source in the same cycle: the old entry is broadcast and the new entry is stored, so throughput is one result per source per cycle when uncontended.
REQ-022 A non-granted full slot holds its contents and deasserts src_ready until granted.
REQ-023 flush high at an edge: all hold_valid and cdb_valid are cleared; transfers presented in that cycle are dropped (src_ready=0); arbitration results of that cycle are discarded.
REQ-024 The rr pointer, data and tag registers are not cleared by flush.

Reset
REQ-025 rst high asynchronously forces hold_valid=0, cdb_valid=0, cdb_tag=0, cdb_data=0 and the rr pointer to 0.
REQ-026 While rst is high, src_ready=0.
REQ-027 rst asserted mid-operation discards all pending results with no partial broadcast.

Configuration
REQ-028 Macro CDB_RR_ARB_EN defined: round-robin arbitration; the search starts at rr pointer p, and p becomes (granted index + 1) mod N_SRC after each grant.
REQ-029 CDB_RR_ARB_EN undefined: fixed priority with lowest index highest; the rr pointer register is not implemented.

Structure
REQ-030 Shared package cdb_pkg holds TAG_W, DATA_W and N_SRC defaults, the source-index constants SRC_ADD=0, SRC_MUL=1 and SRC_DIV=2, and the cdb_bus_t struct (valid, tag, data).
REQ-031 The arbiter is a sub-module cdb_rr_arb (request vector, pointer in; one-hot grant out); it is fully combinational.

Verification
REQ-032 Reset then single add result with tag=3, data=0x0000_00AA -> two edges later cdb_valid=1, tag=3, data=0xAA for one cycle; src_ready[0] stays 1 throughout.
REQ-033 All three sources valid in the same cycle (tags 1, 2, 3) with round-robin enabled -> broadcasts in order tags 1, 2, 3 on consecutive cycles; the next simultaneous burst starts at source 0 again.
REQ-034 Source 0 streams back-to-back with others idle -> one broadcast per cycle with no bubbles and src_ready[0] constantly 1.
REQ-035 Fixed priority with source 0 valid every cycle and source 2 pending -> source 2 is starved and src_ready[2]=0 until source 0 stops.
REQ-036 flush asserted while two slots are full and cdb_valid=1 -> next cycle cdb_valid=0, all src_ready=1, and no stale tag is ever broadcast.
REQ-037 rst pulsed asynchronously mid-burst between edges -> outputs zero immediately; after release, a new result is broadcast with its own tag only.
